// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, default
// bit timing and LSR bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam int LSR_THRE_BIT = 5;
  localparam int LSR_TEMT_BIT = 6;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push is refused when full and pop
// when empty; the head entry is presented combinationally on rdata_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and occupancy values; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a TX FIFO, with LSR-style status flags and a
// sticky overflow flag for writes that arrive while the FIFO is full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        clr_overflow,
  output logic                        uart_tx,
  output logic                        sim_tx_valid,
  output logic [7:0]                  sim_tx_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        thre,
  output logic                        temt,
  output logic                        overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;

  logic          baud_last_s;
  logic          pop_s;
  logic [7:0]    fifo_rdata_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s, fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign baud_last_s = (baud_q == BAUD_LAST);
  // Final STOP cycle chains straight into the next START, so frames abut.
  assign pop_s = !fifo_empty_s &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last_s));

  // Next-state logic for the frame FSM, baud counter and shifter.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (pop_s) begin
      state_d = ST_START;
      baud_d  = {BW{1'b0}};
      shift_d = fifo_rdata_s;
      tx_d    = 1'b0;
      valid_d = 1'b1;
      data_d  = fifo_rdata_s;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_d = {BW{1'b0}};
          tx_d   = 1'b1;
        end
        ST_START: begin
          if (baud_last_s) begin
            state_d = ST_DATA;
            baud_d  = {BW{1'b0}};
            bit_d   = 3'd0;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            baud_d = baud_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_s && (bit_q == 3'd7)) begin
            state_d = ST_STOP;
            baud_d  = {BW{1'b0}};
            tx_d    = 1'b1;
          end else if (baud_last_s) begin
            baud_d  = {BW{1'b0}};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            baud_d = baud_q + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last_s) begin
            state_d = ST_IDLE;
            baud_d  = {BW{1'b0}};
          end else begin
            baud_d = baud_q + BW'(1);
          end
          tx_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          baud_d  = {BW{1'b0}};
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // Overflow: a dropped write takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx      = tx_q;
  assign sim_tx_valid = valid_q;
  assign sim_tx_data  = data_q;
  assign fifo_count   = fifo_count_s;
  assign thre         = fifo_empty_s;
  assign temt         = fifo_empty_s && (state_q == ST_IDLE);
  assign overflow     = ovf_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       uart_tx;
  logic       sim_tx_valid;
  logic [7:0] sim_tx_data;
  logic [4:0] fifo_count;
  logic       thre;
  logic       temt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .uart_tx      (uart_tx),
    .sim_tx_valid (sim_tx_valid),
    .sim_tx_data  (sim_tx_data),
    .fifo_count   (fifo_count),
    .thre         (thre),
    .temt         (temt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial line level for bit slot n (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return v[n-1];
  endfunction

  // Write one byte from idle, then check the full 40-cycle frame.
  task automatic send_and_check(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    check("count_after_write", fifo_count, 5'd1);
    check("temt_after_write", temt, 1'b0);
    check("tx_idle_before_pop", uart_tx, 1'b1);
    tick();
    check("pop_valid", sim_tx_valid, 1'b1);
    check("pop_data", sim_tx_data, b);
    check("count_after_pop", fifo_count, 5'd0);
    for (int k = 0; k < 40; k++) begin
      check("frame_bit", uart_tx, frame_bit(b, k / 4));
      check("temt_busy", temt, 1'b0);
      if (k > 0) check("valid_single", sim_tx_valid, 1'b0);
      tick();
    end
    check("temt_done", temt, 1'b1);
    check("tx_idle_done", uart_tx, 1'b1);
    check("data_held", sim_tx_data, b);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_tx", uart_tx, 1'b1);
    check("rst_valid", sim_tx_valid, 1'b0);
    check("rst_data", sim_tx_data, 8'h00);
    check("rst_count", fifo_count, 5'd0);
    check("rst_thre", thre, 1'b1);
    check("rst_temt", temt, 1'b1);
    check("rst_ovf", overflow, 1'b0);

    // Single byte 0x41
    send_and_check(8'h41);

    // Back-to-back 0x55, 0xAA
    wr_data = 8'h55;
    wr_en   = 1'b1;
    tick();
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("b2b_count", fifo_count, 5'd1);
    for (int k = 0; k < 80; k++) begin
      check("b2b_bit", uart_tx, frame_bit((k < 40) ? 8'h55 : 8'hAA, (k % 40) / 4));
      check("b2b_valid", sim_tx_valid, ((k == 0) || (k == 40)) ? 1'b1 : 1'b0);
      if (k == 0) check("b2b_data0", sim_tx_data, 8'h55);
      if (k == 40) check("b2b_data1", sim_tx_data, 8'hAA);
      tick();
    end
    check("b2b_temt", temt, 1'b1);

    // Overflow: 18 writes, one popped, 16 buffered, last dropped
    for (int i = 0; i < 18; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
      if (i == 1) begin
        check("ovf_first_valid", sim_tx_valid, 1'b1);
        check("ovf_first_data", sim_tx_data, 8'h00);
      end
      if (i == 15) check("ovf_not_yet", overflow, 1'b0);
    end
    wr_en = 1'b0;
    check("ovf_count_full", fifo_count, 5'd16);
    check("ovf_set", overflow, 1'b1);
    check("ovf_thre", thre, 1'b0);
    for (int c = 0; c < 23; c++) begin
      tick();
      check("ovf_wait_valid", sim_tx_valid, 1'b0);
    end
    check("ovf_wait_count", fifo_count, 5'd16);
    // Write on the STOP-final pop cycle while full, clear requested too
    wr_data      = 8'hEE;
    wr_en        = 1'b1;
    clr_overflow = 1'b1;
    tick();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    check("popcyc_valid", sim_tx_valid, 1'b1);
    check("popcyc_data", sim_tx_data, 8'h01);
    check("popcyc_count", fifo_count, 5'd15);
    check("popcyc_ovf_set_wins", overflow, 1'b1);
    for (int j = 2; j <= 16; j++) begin
      for (int c = 0; c < 40; c++) begin
        tick();
        if (c < 39) begin
          check("order_gap", sim_tx_valid, 1'b0);
        end else begin
          check("order_valid", sim_tx_valid, 1'b1);
          check("order_data", sim_tx_data, 8'(j));
          check("order_count", fifo_count, 5'(16 - j));
        end
      end
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      check("no_dropped_byte", sim_tx_valid, 1'b0);
    end
    check("ovf_drain_temt", temt, 1'b1);
    check("ovf_still_set", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Reset mid-DATA with 5 bytes queued
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i);
      tick();
      if (i == 1) check("rstmid_pop_data", sim_tx_data, 8'h3C);
    end
    wr_en = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("rstmid_count", fifo_count, 5'd5);
    check("rstmid_busy", temt, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_tx", uart_tx, 1'b1);
    check("rstmid_count0", fifo_count, 5'd0);
    check("rstmid_temt", temt, 1'b1);
    check("rstmid_thre", thre, 1'b1);
    check("rstmid_data", sim_tx_data, 8'h00);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rstmid_quiet_tx", uart_tx, 1'b1);
      check("rstmid_quiet_valid", sim_tx_valid, 1'b0);
    end
    send_and_check(8'h7E);

    // Write during reset is ignored
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    check("wr_in_rst_count", fifo_count, 5'd0);
    tick();
    check("wr_in_rst_valid", sim_tx_valid, 1'b0);
    check("wr_in_rst_temt", temt, 1'b1);
    check("wr_in_rst_tx", uart_tx, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
